// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and helpers for the fetch/load-store memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_MEM_LATENCY  = 1;
  localparam int DEF_STARVE_LIMIT = 4;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating counter of data grants taken while a fetch is waiting.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LIMIT_VAL = CW'(LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LIMIT_VAL)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign at_limit = (r_cnt == LIMIT_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// tracking one outstanding read and returning its data with a one-cycle valid.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_ren_o,
  output logic                  mem_wren_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  // Handshake: a requester holds req (and its address/data) until it sees gnt
  // in the same cycle; gnt is combinational, so the transfer happens in the
  // cycle where req && gnt. rvalid is a one-cycle pulse MEM_LATENCY cycles
  // after the read grant, and rdata holds its value until the next rvalid.

  localparam int LW = cnt_width(MEM_LATENCY);
  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LATENCY);
  localparam logic [LW-1:0] LAT_ONE  = LW'(1);

  arb_state_e r_state, w_state_nxt;
  owner_e     r_owner, w_owner_nxt;
  logic [LW-1:0] r_lat_cnt, w_lat_nxt;
  logic [DATA_WIDTH-1:0] r_if_rdata, r_d_rdata;

  logic w_free, w_if_win, w_d_win, w_rd_grant, w_rsp, w_at_limit;

  // The last wait cycle also counts as free so reads can issue back-to-back.
  assign w_rsp      = (r_state == ARB_RD_WAIT) && (r_lat_cnt == LAT_ONE);
  assign w_free     = !rst && ((r_state == ARB_IDLE) || w_rsp);
  assign w_if_win   = w_free && if_req_i && (!d_req_i || w_at_limit);
  assign w_d_win    = w_free && d_req_i && !w_if_win;
  assign w_rd_grant = w_if_win || (w_d_win && !d_we_i);

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (w_d_win && if_req_i),
    .clr     (w_if_win || !if_req_i),
    .at_limit(w_at_limit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_lat_nxt   = r_lat_cnt;
    if (w_rd_grant) begin
      w_state_nxt = ARB_RD_WAIT;
      w_lat_nxt   = LAT_INIT;
      w_owner_nxt = w_if_win ? OWN_IF : OWN_D;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          w_state_nxt = ARB_IDLE;
        end
        ARB_RD_WAIT: begin
          if (r_lat_cnt == LAT_ONE) begin
            w_state_nxt = ARB_IDLE;
            w_owner_nxt = OWN_NONE;
            w_lat_nxt   = '0;
          end else begin
            w_lat_nxt = r_lat_cnt - LAT_ONE;
          end
        end
        default: begin
          w_state_nxt = ARB_IDLE;
          w_owner_nxt = OWN_NONE;
          w_lat_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_owner    <= OWN_NONE;
      r_lat_cnt  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_lat_cnt <= w_lat_nxt;
      if (if_rvalid_o) r_if_rdata <= mem_rdata_i;
      if (d_rvalid_o)  r_d_rdata  <= mem_rdata_i;
    end
  end

  assign if_gnt_o    = w_if_win;
  assign d_gnt_o     = w_d_win;
  assign mem_ren_o   = w_rd_grant;
  assign mem_wren_o  = w_d_win && d_we_i;
  assign mem_addr_o  = w_if_win ? if_addr_i : (w_d_win ? d_addr_i : '0);
  assign mem_wdata_o = w_d_win ? d_wdata_i : '0;

  assign if_rvalid_o = w_rsp && (r_owner == OWN_IF);
  assign d_rvalid_o  = w_rsp && (r_owner == OWN_D);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : r_if_rdata;
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) driven by
// directed and random traffic, checked by a scoreboard fed from a reference model.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        is_if;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  // clock / cycle counter
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [99:0] act, input logic [99:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (i * 32'h0101_0103);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rst = 1'b1;
    logic        init = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_ren, mem_wren;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(STARVE)
    ) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
      .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
      .mem_ren_o(mem_ren), .mem_wren_o(mem_wren), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // clocked memory with LAT-deep read pipeline
    logic [31:0] mem [64];
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
      if (init) begin
        for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (mem_wren) begin
        mem[mem_addr[7:2]] <= mem_wdata;
      end
      pipe[0] <= mem_ren ? mem[mem_addr[7:2]] : 32'h0;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[LAT-1];

    // reference model state and scoreboard queues
    logic        p_rst = 1'b1, p_if_req = 1'b0, p_d_req = 1'b0, p_d_we = 1'b0;
    logic [31:0] p_if_addr = '0, p_d_addr = '0, p_d_wdata = '0;
    logic [31:0] ref_mem [64];
    int          free_cyc = 0;
    int          starve = 0;
    txn_t        exp_q[$];
    rsp_t        rd_q[$];

    task automatic step();
      logic gi, gd;
      @(posedge clk);
      #1;
      rst = p_rst; if_req = p_if_req; if_addr = p_if_addr;
      d_req = p_d_req; d_we = p_d_we; d_addr = p_d_addr; d_wdata = p_d_wdata;
      if (p_rst) begin
        rd_q.delete();
        starve = 0;
        free_cyc = 0;
      end else begin
        gi = (cyc >= free_cyc) && p_if_req && (!p_d_req || starve == STARVE);
        gd = (cyc >= free_cyc) && p_d_req && !gi;
        if (gi) begin
          exp_q.push_back('{cyc: cyc, is_if: 1'b1, we: 1'b0, addr: p_if_addr, wdata: 32'h0});
          rd_q.push_back('{cyc: cyc + LAT, is_if: 1'b1, data: ref_mem[p_if_addr[7:2]]});
          free_cyc = cyc + LAT;
          p_if_req = 1'b0;
        end else if (gd) begin
          exp_q.push_back('{cyc: cyc, is_if: 1'b0, we: p_d_we, addr: p_d_addr, wdata: p_d_wdata});
          if (p_d_we) begin
            ref_mem[p_d_addr[7:2]] = p_d_wdata;
            free_cyc = cyc + 1;
          end else begin
            rd_q.push_back('{cyc: cyc + LAT, is_if: 1'b0, data: ref_mem[p_d_addr[7:2]]});
            free_cyc = cyc + LAT;
          end
          p_d_req = 1'b0;
        end
        if (gi || !if_req) starve = 0;
        else if (gd && starve < STARVE) starve++;
      end
    endtask

    task automatic drain();
      for (int i = 0; i < 40 && (p_if_req || p_d_req); i++) step();
    endtask

    task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue_d(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      p_d_req = 1'b1; p_d_we = we; p_d_addr = addr; p_d_wdata = wd;
    endtask

    // driver
    initial begin
      int n;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      idle(2);
      init = 1'b0;
      p_rst = 1'b0;
      // fetch-only stream
      for (int k = 0; k < 4; k++) begin
        p_if_req = 1'b1; p_if_addr = 32'(k * 4);
        drain();
      end
      idle(4);
      // simultaneous requests: data preferred, fetch follows
      p_if_req = 1'b1; p_if_addr = 32'h14;
      issue_d(1'b0, 32'h10, 32'h0);
      drain();
      idle(4);
      // sustained data traffic against a waiting fetch
      p_if_req = 1'b1; p_if_addr = 32'h30;
      n = 0;
      for (int i = 0; i < 60 && (n < 6 || p_d_req || p_if_req); i++) begin
        if (!p_d_req && n < 6) begin
          issue_d(1'b0, 32'(32'h40 + 4 * n), 32'h0);
          n++;
        end
        step();
      end
      idle(4);
      // store then load of the same word
      issue_d(1'b1, 32'h20, 32'hDEADBEEF);
      drain();
      issue_d(1'b0, 32'h20, 32'h0);
      drain();
      idle(4);
      // read with a fetch queued behind it
      issue_d(1'b0, 32'h24, 32'h0);
      step();
      p_if_req = 1'b1; p_if_addr = 32'h28;
      drain();
      idle(5);
      // reset while a load is outstanding
      issue_d(1'b0, 32'h2C, 32'h0);
      drain();
      p_rst = 1'b1;
      p_if_req = 1'b1; p_if_addr = 32'h34;
      idle(2);
      p_rst = 1'b0;
      drain();
      idle(5);
      // random traffic
      for (int i = 0; i < 400; i++) begin
        if (!p_if_req && $urandom_range(0, 2) == 0) begin
          p_if_req = 1'b1; p_if_addr = 32'($urandom_range(0, 63) * 4);
        end
        if (!p_d_req && $urandom_range(0, 1) == 0)
          issue_d($urandom_range(0, 2) == 0, 32'($urandom_range(0, 63) * 4), $urandom);
        else if (p_d_req && $urandom_range(0, 19) == 0)
          p_d_req = 1'b0;
        p_rst = ($urandom_range(0, 99) == 0);
        step();
      end
      p_rst = 1'b0;
      drain();
      idle(6);
      done_cnt++;
    end

    // monitor: pops expectations and compares against DUT outputs each cycle
    initial begin
      txn_t        e;
      rsp_t        r;
      logic [99:0] exp_v;
      logic        ev_if, ev_d;
      logic [31:0] h_if, h_d;
      h_if = '0;
      h_d = '0;
      forever begin
        @(negedge clk);
        exp_v = '0;
        if (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
          e = exp_q.pop_front();
          exp_v = 100'({e.is_if, !e.is_if, e.is_if || !e.we, !e.is_if && e.we, e.addr, e.wdata});
        end
        chk($sformatf("lat%0d_mem_port", LAT),
            100'({if_gnt, d_gnt, mem_ren, mem_wren, mem_addr, mem_wdata}), exp_v);
        ev_if = 1'b0;
        ev_d = 1'b0;
        if (rst) begin
          h_if = '0;
          h_d = '0;
        end
        if (rd_q.size() > 0 && rd_q[0].cyc == 32'(cyc)) begin
          r = rd_q.pop_front();
          ev_if = r.is_if;
          ev_d = !r.is_if;
          if (r.is_if) h_if = r.data;
          else h_d = r.data;
        end
        chk($sformatf("lat%0d_read_rsp", LAT),
            100'({if_rvalid, d_rvalid, if_rdata, d_rdata}), 100'({ev_if, ev_d, h_if, h_d}));
      end
    end
  end

  // final report
  initial begin
    for (int t = 0; t < 20000 && done_cnt < 2; t++) @(posedge clk);
    chk("both_streams_done", 100'(done_cnt), 100'(2));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
